// File: rtl/demux1x2_stream.sv
// Packet-aware 1:2 stream demultiplexer: in_sel on a packet's first beat picks
// port A or B, and the route stays locked until the last beat is accepted.
// Optional per-port packet counters are enabled by the DEMUX_PKT_CNT_EN macro.
module demux1x2_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last,
  input  logic             b_ready,
  output logic [7:0]       a_pkts,
  output logic [7:0]       b_pkts
);

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} state_t;

  state_t state, state_next;
  logic   to_b;
  logic   accept;
  logic   acc_a, acc_b;

  // in_ready looks only at the target port, so a stalled non-target port
  // never blocks the packet in flight.
  assign in_ready = to_b ? (!b_valid || b_ready) : (!a_valid || a_ready);
  assign accept   = in_valid && in_ready;
  assign acc_a    = accept && !to_b;
  assign acc_b    = accept && to_b;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    to_b       = 1'b0;
    state_next = state;
    case (state)
      IDLE:    to_b = in_sel;
      ROUTE_B: to_b = 1'b1;
      default: to_b = 1'b0;
    endcase
    if (accept) begin
      if (in_last)
        state_next = IDLE;
      else if (state == IDLE)
        state_next = in_sel ? ROUTE_B : ROUTE_A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Output registers reload on an accept even while draining, which keeps a
  // streaming port at one beat per cycle.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are reset as well as valid, so outputs read
    // as zero after reset rather than stale data.
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_last  <= 1'b0;
    end else if (acc_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
      a_last  <= in_last;
    end else if (a_valid && a_ready) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_last  <= 1'b0;
    end else if (acc_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
      b_last  <= in_last;
    end else if (b_valid && b_ready) begin
      b_valid <= 1'b0;
    end
  end

`ifdef DEMUX_PKT_CNT_EN
  logic [7:0] a_cnt, b_cnt;

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (acc_a && in_last) a_cnt <= a_cnt + 8'd1;
      if (acc_b && in_last) b_cnt <= b_cnt + 8'd1;
    end
  end

  assign a_pkts = a_cnt;
  assign b_pkts = b_cnt;
`else
  assign a_pkts = '0;
  assign b_pkts = '0;
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: a per-port scoreboard checks routing,
// ordering, in_ready and counters every cycle, alongside directed sequences.
module tb_demux1x2_stream;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last, in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_last, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] b_data;
  logic [7:0]       a_pkts, b_pkts;

  int checks   = 0;
  int failures = 0;

  demux1x2_stream #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .a_pkts(a_pkts), .b_pkts(b_pkts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef enum int {M_IDLE, M_A, M_B} mstate_t;

  beat_t      qa[$];
  beat_t      qb[$];
  mstate_t    m_state = M_IDLE;
  logic [7:0] m_a_pkts = '0;
  logic [7:0] m_b_pkts = '0;

  always @(negedge clk) begin
    logic  tgt_b, exp_rdy, acc;
    beat_t e;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_state  = M_IDLE;
      m_a_pkts = '0;
      m_b_pkts = '0;
    end else begin
      tgt_b   = (m_state == M_IDLE) ? in_sel : (m_state == M_B);
      exp_rdy = tgt_b ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
      check("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("sb_a_valid", 32'(a_valid), 32'(qa.size() != 0));
      check("sb_b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (a_valid && a_ready && qa.size() != 0) begin
        e = qa.pop_front();
        check("sb_a_data", 32'(a_data), 32'(e.data));
        check("sb_a_last", 32'(a_last), 32'(e.last));
      end
      if (b_valid && b_ready && qb.size() != 0) begin
        e = qb.pop_front();
        check("sb_b_data", 32'(b_data), 32'(e.data));
        check("sb_b_last", 32'(b_last), 32'(e.last));
      end
`ifdef DEMUX_PKT_CNT_EN
      check("sb_a_pkts", 32'(a_pkts), 32'(m_a_pkts));
      check("sb_b_pkts", 32'(b_pkts), 32'(m_b_pkts));
`else
      check("sb_a_pkts", 32'(a_pkts), 32'd0);
      check("sb_b_pkts", 32'(b_pkts), 32'd0);
`endif
      acc = in_valid && exp_rdy;
      if (acc) begin
        e.data = in_data;
        e.last = in_last;
        if (tgt_b) begin
          qb.push_back(e);
          if (in_last) m_b_pkts = m_b_pkts + 8'd1;
        end else begin
          qa.push_back(e);
          if (in_last) m_a_pkts = m_a_pkts + 8'd1;
        end
        if (in_last)               m_state = M_IDLE;
        else if (m_state == M_IDLE) m_state = tgt_b ? M_B : M_A;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                       input logic last, input logic ar, input logic br);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
    a_ready  = ar;
    b_ready  = br;
  endtask

  typedef struct {
    logic             v;
    logic             sel;
    logic [WIDTH-1:0] d;
    logic             last;
    logic             ar;
    logic             br;
    logic             exp_rdy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // 3-beat packet to B with in_sel toggling, then A backpressure with a B bypass.
    vecs[0] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_b_last",  32'(b_last),  32'd0);
    check("rst_a_pkts",  32'(a_pkts),  32'd0);
    check("rst_b_pkts",  32'(b_pkts),  32'd0);

    // Single beat to A, one-cycle latency
    cyc(); drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b1);
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("single_a_valid", 32'(a_valid), 32'd1);
    check("single_a_data",  32'(a_data),  32'hA);
    check("single_b_valid", 32'(b_valid), 32'd0);

    // Still IDLE: the next beat follows in_sel to B
    cyc(); drive(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_b_valid", 32'(b_valid), 32'd1);
    check("idle_b_data",  32'(b_data),  32'h5);
    check("idle_a_valid", 32'(a_valid), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      cyc();
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].last, vecs[i].ar, vecs[i].br);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
    end

    // Streaming 8 beats to A, no bubbles
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive(1'b1, 1'b0, 4'(i + 3), 1'(i == 7), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0) check($sformatf("stream%0d_a_valid", i), 32'(a_valid), 32'd1);
    end
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Reset mid-packet to B
    cyc(); drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1);
    cyc(); drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1);
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("midrst_b_valid", 32'(b_valid), 32'd0);
    check("midrst_a_valid", 32'(a_valid), 32'd0);
    cyc(); drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b1, 1'b1);
    cyc(); drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("postrst_a_valid", 32'(a_valid), 32'd1);
    check("postrst_a_data",  32'(a_data),  32'h9);
    check("postrst_b_valid", 32'(b_valid), 32'd0);
    cyc(); drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1);
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("locked_a_data", 32'(a_data), 32'hC);
    check("locked_b_valid", 32'(b_valid), 32'd0);

    // 257 single-beat packets to A: counter wraps
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 257; i++) begin
      cyc(); drive(1'b1, 1'b0, 4'(i), 1'b1, 1'b1, 1'b1);
    end
    cyc(); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc();
    @(negedge clk);
`ifdef DEMUX_PKT_CNT_EN
    check("wrap_a_pkts", 32'(a_pkts), 32'd1);
`else
    check("wrap_a_pkts", 32'(a_pkts), 32'd0);
`endif
    check("wrap_b_pkts", 32'(b_pkts), 32'd0);

    check("drain_qa", 32'(qa.size()), 32'd0);
    check("drain_qb", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
